ws2811_frame_sequencer: RTL and testbench

Generalised frame engine for WS2811 strings. It streams one 24-bit colour word per unit from an external synchronous pattern memory into the WS2811 transmitter. Frames fire at a fixed update rate, and the pattern window scrolls by a programmable step and direction each frame. Each word is brightness-scaled per channel, and every frame ends with a guaranteed latch gap. It sits between the pattern ROM/RAM and the WS2811 transmitter, replacing the fixed top-level scroller.

---
 rtl/ws2811_frame_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_ws2811_frame_sequencer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ws2811_frame_sequencer.sv
// Frame engine for WS2811 strings: streams brightness-scaled pattern words to the
// transmitter once per update tick, scrolling the pattern window every frame.
module ws2811_frame_sequencer #(
  parameter int UNITS_NUMBER          = 100,
  parameter int PATTERN_PIXELS_NUMBER = 128,
  parameter int CLOCK_SPEED           = 50_000_000,
  parameter int UPDATES_PER_SECOND    = 20,
  parameter int LATCH_CYCLES          = 3000,
  parameter int STEP_WIDTH            = 4
) (
  input  logic                                     clkIN,
  input  logic                                     resetIN,
  input  logic                                     enableIN,
  input  logic                                     directionIN,
  input  logic [STEP_WIDTH-1:0]                    stepIN,
  input  logic [7:0]                               brightnessIN,
  output logic [$clog2(PATTERN_PIXELS_NUMBER)-1:0] romAddressOUT,
  input  logic [23:0]                              romDataIN,
  output logic                                     txStartOUT,
  output logic [23:0]                              txDataOUT,
  input  logic                                     txBusyIN,
  output logic                                     frameBusyOUT,
  output logic                                     frameDoneOUT,
  output logic                                     overrunOUT
);

  localparam int AW          = $clog2(PATTERN_PIXELS_NUMBER);
  localparam int TICK_PERIOD = CLOCK_SPEED / UPDATES_PER_SECOND;
  localparam int TW          = (TICK_PERIOD > 1) ? $clog2(TICK_PERIOD) : 1;
  localparam int UW          = $clog2(UNITS_NUMBER + 1);
  localparam int LW          = $clog2(LATCH_CYCLES);
  localparam logic [31:0] DEPTH32    = 32'(PATTERN_PIXELS_NUMBER);
  localparam logic [AW:0] DEPTH_W    = (AW+1)'(PATTERN_PIXELS_NUMBER);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_PERIOD - 1);
  // The busy-low cycle is the first gap clock, so LATCH itself lasts one clock less.
  localparam logic [LW-1:0] LATCH_LAST = LW'(LATCH_CYCLES - 2);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT_DATA, S_SEND, S_WAIT_BUSY, S_LATCH
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
  logic [AW-1:0]   offset_q, offset_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic [UW-1:0]   unit_q, unit_d;
  logic [7:0]      bright_q, bright_d;
  logic [LW-1:0]   latch_cnt_q, latch_cnt_d;
  logic            first_q, first_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            tx_start_q, tx_start_d;
  logic [23:0]     tx_data_q, tx_data_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            overrun_q, overrun_d;

  logic            tick;
  logic [AW:0]     step_mod, off_ext, sum_up, off_up, off_dn;
  logic [AW-1:0]   next_offset, ptr_inc;
  logic [UW-1:0]   unit_inc;
  logic [23:0]     scaled;
  logic [8:0]      bright_plus;

  assign tick = (tick_cnt_q == TICK_LAST);

  // Offsets stay in [0, depth): a single conditional subtract/add is enough once
  // the step itself is reduced below the depth.
  assign step_mod    = (AW+1)'(32'(stepIN) % DEPTH32);
  assign off_ext     = {1'b0, offset_q};
  assign sum_up      = off_ext + step_mod;
  assign off_up      = (sum_up >= DEPTH_W) ? sum_up - DEPTH_W : sum_up;
  assign off_dn      = (off_ext >= step_mod) ? off_ext - step_mod : off_ext + DEPTH_W - step_mod;
  assign next_offset = AW'(directionIN ? off_dn : off_up);
  assign ptr_inc     = (({1'b0, ptr_q} + 1'b1) == DEPTH_W) ? '0 : ptr_q + 1'b1;
  assign unit_inc    = unit_q + 1'b1;
  assign bright_plus = {1'b0, bright_q} + 9'd1;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_scale
      logic [16:0] prod;
      assign prod = {9'b0, romDataIN[8*gi +: 8]} * {8'b0, bright_plus};
      assign scaled[8*gi +: 8] = 8'(prod >> 8);
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick ? '0 : tick_cnt_q + 1'b1;
    offset_d    = offset_q;
    ptr_d       = ptr_q;
    unit_d      = unit_q;
    bright_d    = bright_q;
    latch_cnt_d = latch_cnt_q;
    first_d     = first_q;
    addr_d      = addr_q;
    tx_start_d  = 1'b0;
    tx_data_d   = tx_data_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    overrun_d   = overrun_q | (tick & (state_q != S_IDLE));
    case (state_q)
      S_IDLE: begin
        if (tick && enableIN) begin
          offset_d = next_offset;
          ptr_d    = next_offset;
          bright_d = brightnessIN;
          unit_d   = '0;
          busy_d   = 1'b1;
          state_d  = S_FETCH;
        end
      end
      S_FETCH: begin
        addr_d  = ptr_q;
        state_d = S_WAIT_DATA;
      end
      S_WAIT_DATA: state_d = S_SEND;
      S_SEND: begin
        tx_data_d  = scaled;
        tx_start_d = 1'b1;
        first_d    = 1'b1;
        state_d    = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (first_q) begin
          first_d = 1'b0;
        end else if (!txBusyIN) begin
          unit_d = unit_inc;
          ptr_d  = ptr_inc;
          if (unit_inc == UW'(UNITS_NUMBER)) begin
            latch_cnt_d = '0;
            state_d     = S_LATCH;
          end else begin
            state_d = S_FETCH;
          end
        end
      end
      S_LATCH: begin
        if (latch_cnt_q == LATCH_LAST) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          latch_cnt_d = latch_cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clkIN) begin
    if (resetIN) begin
      state_q     <= S_IDLE;
      tick_cnt_q  <= '0;
      offset_q    <= '0;
      ptr_q       <= '0;
      unit_q      <= '0;
      bright_q    <= '0;
      latch_cnt_q <= '0;
      first_q     <= 1'b0;
      addr_q      <= '0;
      tx_start_q  <= 1'b0;
      tx_data_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      offset_q    <= offset_d;
      ptr_q       <= ptr_d;
      unit_q      <= unit_d;
      bright_q    <= bright_d;
      latch_cnt_q <= latch_cnt_d;
      first_q     <= first_d;
      addr_q      <= addr_d;
      tx_start_q  <= tx_start_d;
      tx_data_q   <= tx_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      overrun_q   <= overrun_d;
    end
  end

  assign romAddressOUT = addr_q;
  assign txStartOUT    = tx_start_q;
  assign txDataOUT     = tx_data_q;
  assign frameBusyOUT  = busy_q;
  assign frameDoneOUT  = done_q;
  assign overrunOUT    = overrun_q;

endmodule

// File: tb/tb_ws2811_frame_sequencer.sv
// Randomized scoreboard bench: a frame-level reference model predicts every
// transmitted word, frame busy/done timing and the overrun flag.
module tb_ws2811_frame_sequencer;

  localparam int UNITS = 4;
  localparam int DEPTH = 5;
  localparam int CSPD  = 200;
  localparam int UPS   = 1;
  localparam int LATCH = 20;
  localparam int SW    = 4;
  localparam int P     = CSPD / UPS;
  localparam int AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          resetIN = 1'b1;
  logic          enableIN = 1'b0;
  logic          directionIN = 1'b0;
  logic [SW-1:0] stepIN = '0;
  logic [7:0]    brightnessIN = '0;
  logic [AW-1:0] romAddressOUT;
  logic [23:0]   romDataIN;
  logic          txStartOUT;
  logic [23:0]   txDataOUT;
  logic          txBusyIN = 1'b0;
  logic          frameBusyOUT, frameDoneOUT, overrunOUT;

  always #5 clk = ~clk;

  ws2811_frame_sequencer #(
    .UNITS_NUMBER(UNITS), .PATTERN_PIXELS_NUMBER(DEPTH), .CLOCK_SPEED(CSPD),
    .UPDATES_PER_SECOND(UPS), .LATCH_CYCLES(LATCH), .STEP_WIDTH(SW)
  ) dut (
    .clkIN(clk), .resetIN(resetIN), .enableIN(enableIN), .directionIN(directionIN),
    .stepIN(stepIN), .brightnessIN(brightnessIN), .romAddressOUT(romAddressOUT),
    .romDataIN(romDataIN), .txStartOUT(txStartOUT), .txDataOUT(txDataOUT),
    .txBusyIN(txBusyIN), .frameBusyOUT(frameBusyOUT), .frameDoneOUT(frameDoneOUT),
    .overrunOUT(overrunOUT)
  );

  // Synchronous pattern memory with one clock of read latency.
  logic [23:0]   rom [DEPTH];
  logic [23:0]   rom_data;
  logic [AW-1:0] rom_data_addr;
  always @(posedge clk) begin
    rom_data      <= rom[romAddressOUT];
    rom_data_addr <= romAddressOUT;
  end
  assign romDataIN = rom_data;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int addr; logic [23:0] data; } exp_t;
  exp_t exp_q[$];
  int   done_q[$];
  int   tests = 0, fails = 0;
  int   rel_cyc = 0, model_off = 0, st, a;
  bit   exp_fb = 0, exp_ovr = 0, done_now, tick_now;
  int   tx_rem = 0, tx_units = 0, busy_min = 1, busy_max = 10;
  logic [AW-1:0] prev_addr = '0;
  exp_t e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic logic [23:0] scale(input logic [23:0] w, input int b);
    logic [23:0] r;
    int ch;
    r = '0;
    for (int c = 0; c < 3; c++) begin
      ch = int'((w >> (8 * c)) & 24'hFF);
      r |= 24'(((ch * (b + 1)) >> 8) << (8 * c));
    end
    return r;
  endfunction

  // Reference model and monitor.
  initial forever begin
    @(negedge clk);
    if (resetIN) begin
      exp_q.delete();
      done_q.delete();
      rel_cyc   = cyc + 1;
      model_off = 0;
      exp_fb    = 0;
      exp_ovr   = 0;
    end else begin
      done_now = (done_q.size() > 0) && (done_q[0] == cyc);
      tick_now = (cyc >= rel_cyc) && (((cyc - rel_cyc) % P) == P - 1);
      if (done_now) begin
        void'(done_q.pop_front());
        exp_fb = 0;
      end
      check("frame_done", 32'(frameDoneOUT), 32'(done_now));
      check("frame_busy", 32'(frameBusyOUT), 32'(exp_fb));
      check("overrun", 32'(overrunOUT), 32'(exp_ovr));
      if (txStartOUT) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_start: got start with data %0h expected none (cycle %0d)", txDataOUT, cyc);
        end else begin
          e = exp_q.pop_front();
          $display("[TB] cycle %0d start addr %0d data %06h (expected addr %0d data %06h)",
                   cyc, prev_addr, txDataOUT, e.addr, e.data);
          check("tx_addr", 32'(prev_addr), 32'(e.addr));
          check("tx_data", 32'(txDataOUT), 32'(e.data));
        end
      end
      if (tick_now) begin
        if (exp_fb) exp_ovr = 1;
        else if (enableIN) begin
          st = int'(stepIN) % DEPTH;
          model_off = directionIN ? (model_off - st + DEPTH) % DEPTH : (model_off + st) % DEPTH;
          for (int u = 0; u < UNITS; u++) begin
            a = (model_off + u) % DEPTH;
            exp_q.push_back('{addr: a, data: scale(rom[a], int'(brightnessIN))});
          end
          exp_fb = 1;
        end
      end
    end
    prev_addr = rom_data_addr;
  end

  // Transmitter model: busy for a random number of clocks after each start.
  initial forever begin
    @(negedge clk);
    if (resetIN) begin
      txBusyIN = 1'b0;
      tx_rem   = 0;
      tx_units = 0;
    end else if (tx_rem > 0) begin
      tx_rem--;
      if (tx_rem == 0) begin
        txBusyIN = 1'b0;
        tx_units++;
        if (tx_units == UNITS) begin
          done_q.push_back(cyc + LATCH);
          tx_units = 0;
        end
      end
    end else if (txStartOUT) begin
      txBusyIN = 1'b1;
      tx_rem   = int'($urandom_range(busy_max, busy_min));
    end
  end

  task automatic randomize_inputs();
    if ($urandom_range(15, 0) == 0) enableIN = ($urandom_range(3, 0) != 0);
    stepIN      = SW'($urandom);
    directionIN = 1'($urandom);
    case ($urandom_range(3, 0))
      0:       brightnessIN = 8'd0;
      1:       brightnessIN = 8'd255;
      default: brightnessIN = 8'($urandom);
    endcase
  endtask

  bit found;

  initial begin
    for (int i = 0; i < DEPTH; i++) rom[i] = 24'($urandom);
    rom[3] = 24'hFF8001;
    repeat (5) @(posedge clk);
    #1 resetIN = 1'b0;
    @(negedge clk);
    check("rst_addr", 32'(romAddressOUT), 32'd0);
    check("rst_txdata", 32'(txDataOUT), 32'd0);
    check("rst_txstart", 32'(txStartOUT), 32'd0);
    check("rst_busy", 32'(frameBusyOUT), 32'd0);
    check("rst_done", 32'(frameDoneOUT), 32'd0);
    check("rst_overrun", 32'(overrunOUT), 32'd0);

    // Two tick periods with enable low: nothing may start.
    repeat (2 * P) @(posedge clk);

    // Directed scroll: step 3 forward three frames, then one frame backward.
    for (int f = 0; f < 4; f++) begin
      #1;
      enableIN     = 1'b1;
      stepIN       = SW'(3);
      directionIN  = (f == 3);
      brightnessIN = (f == 1) ? 8'd127 : (f == 2) ? 8'd0 : 8'd255;
      repeat (P) @(posedge clk);
    end

    // Randomized frames; enable toggles occasionally, including mid-frame.
    for (int i = 0; i < 8 * P; i++) begin
      #1 randomize_inputs();
      @(posedge clk);
    end

    // Long transmitter busy: frames outlast the tick period.
    #1;
    enableIN = 1'b1;
    busy_min = 150;
    busy_max = 150;
    repeat (3 * P) @(posedge clk);
    busy_min = 10;
    busy_max = 10;
    repeat (2 * P) @(posedge clk);
    @(negedge clk);
    check("overrun_sticky", 32'(overrunOUT), 32'd1);

    // Reset while waiting on the transmitter for unit 2.
    found = 0;
    for (int i = 0; i < 10 * P && !found; i++) begin
      @(posedge clk);
      #1;
      if (tx_units == 2 && tx_rem > 0) found = 1;
    end
    if (!found) begin
      tests++;
      fails++;
      $display("FAIL midframe_wait: got timeout expected unit 2 in flight");
    end else begin
      resetIN = 1'b1;
      @(posedge clk);
      #1 resetIN = 1'b0;
      @(negedge clk);
      check("midrst_busy", 32'(frameBusyOUT), 32'd0);
      check("midrst_overrun", 32'(overrunOUT), 32'd0);
      check("midrst_txdata", 32'(txDataOUT), 32'd0);
    end
    busy_min = 1;
    for (int i = 0; i < 3 * P; i++) begin
      @(posedge clk);
      #1;
      enableIN = 1'b1;
      if (i % P == 0) begin
        stepIN       = SW'($urandom);
        directionIN  = 1'($urandom);
        brightnessIN = 8'($urandom);
      end
    end

    // Drain outstanding frames.
    enableIN = 1'b0;
    for (int i = 0; i < 4 * P && (exp_q.size() > 0 || done_q.size() > 0); i++) @(posedge clk);
    @(negedge clk);
    check("drain_tx", 32'(exp_q.size()), 32'd0);
    check("drain_done", 32'(done_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
